ddr_rd_checker: RTL and testbench

- AXI4 read-side checker for the DDR3 memory test path; the reader for the pattern writer that fills DDR through the controller's AXI port.
- After `ddr_init_done`, a `start` pulse makes it issue fixed-length INCR read bursts over a contiguous address window.
- Every returned beat is compared against the address-derived pattern the writer produced; mismatches are counted.
- Drives the sticky error flag behind `err_flag_led` and a done pulse for the test sequencer.

---
 rtl/ddr_rd_checker_if.sv | 37 +++
 rtl/ddr_rd_checker.sv | 162 ++++++++++++++++
 tb/tb_ddr_rd_checker.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_rd_checker_if.sv
// AXI4 read-address and read-data channels between the DDR read checker
// and the memory controller's AXI slave port.
interface ddr_rd_checker_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic [ADDR_W-1:0] axi_araddr;
  logic [7:0]        axi_arlen;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [DATA_W-1:0] axi_rdata;
  logic              axi_rvalid;
  logic              axi_rlast;
  logic              axi_rready;

  modport master (
    output axi_araddr,
    output axi_arlen,
    output axi_arvalid,
    output axi_rready,
    input  axi_arready,
    input  axi_rdata,
    input  axi_rvalid,
    input  axi_rlast
  );

  modport slave (
    input  axi_araddr,
    input  axi_arlen,
    input  axi_arvalid,
    input  axi_rready,
    output axi_arready,
    output axi_rdata,
    output axi_rvalid,
    output axi_rlast
  );
endinterface

// File: rtl/ddr_rd_checker.sv
// DDR read-back checker: walks a contiguous window with fixed-length INCR
// bursts, one outstanding at a time, and counts beats that miss the pattern.
module ddr_rd_checker #(
  parameter int                ADDR_W     = 28,
  parameter int                DATA_W     = 128,
  parameter int                BURST_LEN  = 16,
  parameter int                NUM_BURSTS = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]       SEED       = 32'hA5A5_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ddr_init_done,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_flag,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  ddr_rd_checker_if.master  axi
);

  localparam int BEAT_BYTES  = DATA_W / 8;
  localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam int WORDS       = DATA_W / 32;
  localparam int BT_W        = (BURST_LEN  > 1) ? $clog2(BURST_LEN)  : 1;
  localparam int BC_W        = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

  localparam logic [BT_W-1:0] LAST_BEAT  = BT_W'(BURST_LEN - 1);
  localparam logic [BC_W-1:0] LAST_BURST = BC_W'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [ADDR_W-1:0] r_araddr;
  logic [ADDR_W-1:0] r_beat_addr;
  logic [BT_W-1:0]   r_beat_cnt;
  logic [BC_W-1:0]   r_burst_cnt;
  logic [15:0]       r_err_cnt;
  logic              r_err_flag;
  logic [ADDR_W-1:0] r_first_err_addr;

  logic              w_accept;
  logic              w_beat_hs;
  logic              w_last_beat;
  logic              w_last_burst;
  logic              w_beat_err;

  // Expected beat: the zero-extended byte address XOR the seed, in every 32-bit lane.
  function automatic logic [DATA_W-1:0] f_pattern(input logic [ADDR_W-1:0] addr);
    logic [31:0] word;
    word = 32'(addr) ^ SEED;
    return {WORDS{word}};
  endfunction

  function automatic logic [15:0] f_sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  assign w_accept     = (r_state == S_IDLE) && start && ddr_init_done;
  assign w_beat_hs    = (r_state == S_R) && axi.axi_rvalid;
  assign w_last_beat  = (r_beat_cnt == LAST_BEAT);
  assign w_last_burst = (r_burst_cnt == LAST_BURST);

  // A beat with bad data and a misplaced rlast is still a single error.
  assign w_beat_err   = (axi.axi_rdata != f_pattern(r_beat_addr)) ||
                        (axi.axi_rlast != w_last_beat);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_AR;
      S_AR:    if (axi.axi_arready) w_next = S_R;
      S_R:     if (w_beat_hs && w_last_beat) w_next = S_NEXT;
      S_NEXT:  w_next = w_last_burst ? S_DONE : S_AR;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    axi.axi_arvalid = 1'b0;
    axi.axi_rready  = 1'b0;
    case (r_state)
      S_AR: begin
        busy            = 1'b1;
        axi.axi_arvalid = 1'b1;
      end
      S_R: begin
        busy           = 1'b1;
        axi.axi_rready = 1'b1;
      end
      S_NEXT:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Burst and beat addressing; the beat counter, not rlast, closes a burst.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_araddr    <= '0;
      r_beat_addr <= '0;
      r_beat_cnt  <= '0;
      r_burst_cnt <= '0;
    end else if (w_accept) begin
      r_araddr    <= BASE_ADDR;
      r_beat_addr <= BASE_ADDR;
      r_beat_cnt  <= '0;
      r_burst_cnt <= '0;
    end else if (w_beat_hs) begin
      r_beat_addr <= r_beat_addr + ADDR_W'(BEAT_BYTES);
      r_beat_cnt  <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
    end else if (r_state == S_NEXT) begin
      r_araddr    <= r_araddr + ADDR_W'(BURST_BYTES);
      r_burst_cnt <= r_burst_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_cnt        <= '0;
      r_err_flag       <= 1'b0;
      r_first_err_addr <= '0;
    end else if (w_accept) begin
      r_err_cnt        <= '0;
      r_err_flag       <= 1'b0;
      r_first_err_addr <= '0;
    end else if (w_beat_hs && w_beat_err) begin
      r_err_cnt  <= f_sat_inc(r_err_cnt);
      r_err_flag <= 1'b1;
      if (r_err_cnt == 16'd0) begin
        r_first_err_addr <= r_beat_addr;
      end
    end
  end

  assign axi.axi_araddr = r_araddr;
  assign axi.axi_arlen  = 8'(BURST_LEN - 1);
  assign err_cnt        = r_err_cnt;
  assign err_flag       = r_err_flag;
  assign first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_ddr_rd_checker.sv
// Randomised bench for ddr_rd_checker: an AXI read responder plus a
// transaction-level model of the pass that is compared every cycle.
module tb_ddr_rd_checker;

  localparam int          ADDR_W = 28;
  localparam int          DATA_W = 128;
  localparam int          BL     = 4;
  localparam int          NB     = 2;
  localparam int          BASE   = 0;
  localparam logic [31:0] SEED   = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn          = 1'b1;
  logic              ddr_init_done = 1'b0;
  logic              start         = 1'b0;
  logic              busy;
  logic              done;
  logic              err_flag;
  logic [15:0]       err_cnt;
  logic [ADDR_W-1:0] first_err_addr;

  ddr_rd_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ddr_rd_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL), .NUM_BURSTS(NB),
    .BASE_ADDR(28'(BASE)), .SEED(SEED)
  ) dut (
    .clk(clk), .rstn(rstn), .ddr_init_done(ddr_init_done), .start(start),
    .busy(busy), .done(done), .err_flag(err_flag), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .axi(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    logic [31:0]       w;
    logic [DATA_W-1:0] d;
    w = {{(32-ADDR_W){1'b0}}, a} ^ SEED;
    for (int i = 0; i < DATA_W/32; i++) d[i*32 +: 32] = w;
    return d;
  endfunction

  function automatic logic [ADDR_W-1:0] beat_addr(input int burst, input int beat);
    longint t;
    t = longint'(BASE) + longint'(burst*BL + beat) * (DATA_W/8);
    return t[ADDR_W-1:0];
  endfunction

  // Responder knobs, set by the main sequence.
  int                ar_delay    = 0;
  int                rv_mode     = 0;
  int                err_rate    = 0;
  bit                spur_en     = 0;
  bit                flip_en     = 0;
  logic [ADDR_W-1:0] flip_addr   = '0;
  int                flip_bit    = 0;
  bit                rl_fault_en = 0;
  logic [ADDR_W-1:0] rl_fault_addr = '0;
  logic [ADDR_W-1:0] ar_log[$];
  int                done_cnt = 0;

  // Responder state.
  bit                rs_have = 0;
  bit                rs_real = 0;
  bit                rs_tog  = 0;
  int                rs_beat = 0;
  int                rs_cnt  = 0;
  logic [ADDR_W-1:0] rs_addr = '0;

  initial begin : responder
    logic              nar, nv, nl, cons;
    logic [DATA_W-1:0] nd;
    logic [ADDR_W-1:0] a;
    int                b;
    bus.axi_arready = 1'b0;
    bus.axi_rvalid  = 1'b0;
    bus.axi_rdata   = '0;
    bus.axi_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      nv = 1'b0; nd = '0; nl = 1'b0;
      if (!rstn) begin
        rs_have = 0; rs_real = 0; rs_cnt = 0;
      end else begin
        cons = rs_have && rs_real && bus.axi_rvalid && bus.axi_rready;
        if (cons) begin
          rs_beat++;
          if (rs_beat == BL) rs_have = 0;
        end
        if (bus.axi_arvalid && bus.axi_arready) begin
          ar_log.push_back(bus.axi_araddr);
          rs_have = 1; rs_real = 0; rs_addr = bus.axi_araddr; rs_beat = 0; rs_cnt = 0;
        end else if (bus.axi_arvalid) begin
          rs_cnt++;
        end
        if (rs_have && rs_real && !cons) begin
          nv = 1'b1; nd = bus.axi_rdata; nl = bus.axi_rlast;
        end else if (rs_have) begin
          if (rv_mode == 0) nv = 1'b1;
          else if (rv_mode == 1) begin nv = rs_tog; rs_tog = !rs_tog; end
          else nv = ($urandom_range(0, 1) == 1);
          a  = rs_addr + ADDR_W'(rs_beat * (DATA_W/8));
          nd = pat(a);
          nl = (rs_beat == BL-1);
          if (flip_en && a == flip_addr) nd[flip_bit] = ~nd[flip_bit];
          if (rl_fault_en && a == rl_fault_addr) nl = ~nl;
          if (err_rate > 0 && $urandom_range(0, 7) < err_rate) begin
            b = $urandom_range(0, DATA_W-1);
            nd[b] = ~nd[b];
          end
          if (err_rate > 0 && $urandom_range(0, 15) < err_rate) nl = ~nl;
        end else begin
          nv = spur_en && ($urandom_range(0, 1) == 1);
          nd = {4{$urandom}};
          nl = ($urandom_range(0, 1) == 1);
        end
      end
      nar = (rs_cnt >= ar_delay);
      @(posedge clk); #1;
      bus.axi_arready = nar;
      bus.axi_rvalid  = nv;
      bus.axi_rdata   = nd;
      bus.axi_rlast   = nl;
      rs_real         = rs_have && nv;
    end
  end

  // Model of one pass: which handshake the checker is waiting for, how many
  // bursts/beats are done, and the error summary the beats imply.
  bit                m_active, m_ar, m_rd, m_gap, m_done, m_fresh;
  int                m_burst, m_beat;
  logic [15:0]       m_err;
  bit                m_flag;
  logic [ADDR_W-1:0] m_first;

  task automatic model_reset();
    m_active = 0; m_ar = 0; m_rd = 0; m_gap = 0; m_done = 0; m_fresh = 1;
    m_burst = 0; m_beat = 0; m_err = '0; m_flag = 0; m_first = '0;
  endtask

  task automatic model_compare();
    logic [ADDR_W-1:0] ea;
    ea = m_fresh ? '0 : beat_addr(m_burst, 0);
    chk("busy",           busy,             m_active);
    chk("done",           done,             m_done);
    chk("arvalid",        bus.axi_arvalid,  m_ar);
    chk("rready",         bus.axi_rready,   m_rd);
    chk("araddr",         bus.axi_araddr,   ea);
    chk("arlen",          bus.axi_arlen,    BL-1);
    chk("err_cnt",        err_cnt,          m_err);
    chk("err_flag",       err_flag,         m_flag);
    chk("first_err_addr", first_err_addr,   m_first);
  endtask

  task automatic model_advance();
    logic [ADDR_W-1:0] a;
    bit                bad;
    if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start && ddr_init_done) begin
        m_active = 1; m_ar = 1; m_burst = 0; m_beat = 0; m_fresh = 0;
        m_err = '0; m_flag = 0; m_first = '0;
      end
    end else if (m_ar) begin
      if (bus.axi_arready) begin m_ar = 0; m_rd = 1; end
    end else if (m_rd) begin
      if (bus.axi_rvalid) begin
        a   = beat_addr(m_burst, m_beat);
        bad = (bus.axi_rdata !== pat(a)) || (bus.axi_rlast !== (m_beat == BL-1));
        if (bad) begin
          if (m_err == 0) m_first = a;
          if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
          m_flag = 1;
        end
        m_beat++;
        if (m_beat == BL) begin m_beat = 0; m_rd = 0; m_gap = 1; end
      end
    end else if (m_gap) begin
      m_gap = 0;
      m_burst++;
      if (m_burst == NB) begin m_active = 0; m_done = 1; end
      else m_ar = 1;
    end
  endtask

  initial begin : compare
    model_reset();
    forever begin
      @(negedge clk);
      if (!rstn) model_reset();
      if (done === 1'b1) done_cnt++;
      model_compare();
      if (rstn) model_advance();
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = (done === 1'b1);
    end
    chk({name, "_done_seen"}, seen, 1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int d0;
    #1 rstn = 1'b0;
    tick(3);
    rstn = 1'b1;
    tick(2);

    chk("pat_lit",  pat(28'h030), 128'hA5A50030_A5A50030_A5A50030_A5A50030);
    chk("addr_lit", beat_addr(1, 0), 28'h040);

    // start ignored while calibration is incomplete
    pulse_start();
    tick(3);
    chk("noinit_busy",    busy, 0);
    chk("noinit_arvalid", bus.axi_arvalid, 0);
    ddr_init_done = 1'b1;
    tick();

    // clean pass
    ar_log.delete();
    d0 = done_cnt;
    pulse_start();
    wait_done(200, "t1");
    tick(2);
    chk("t1_ar_count", ar_log.size(), 2);
    if (ar_log.size() >= 2) begin
      chk("t1_ar0", ar_log[0], 28'h000);
      chk("t1_ar1", ar_log[1], 28'h040);
    end
    chk("t1_err_cnt",  err_cnt, 0);
    chk("t1_err_flag", err_flag, 0);
    chk("t1_done_cnt", done_cnt - d0, 1);

    // data bit error on beat 0x030
    flip_en = 1; flip_addr = 28'h030; flip_bit = 5;
    pulse_start();
    wait_done(200, "t2");
    chk("t2_err_cnt",   err_cnt, 1);
    chk("t2_err_flag",  err_flag, 1);
    chk("t2_first_err", first_err_addr, 28'h030);
    tick(3);
    chk("t2_flag_sticky", err_flag, 1);
    flip_en = 0;

    // slow arready, gappy rvalid; restart must clear the previous errors
    ar_delay = 7; rv_mode = 1;
    tick(2);
    pulse_start();
    chk("t3_clr_flag", err_flag, 0);
    chk("t3_clr_cnt",  err_cnt, 0);
    chk("t3_arvalid",  bus.axi_arvalid, 1);
    wait_done(300, "t3");
    chk("t3_err_cnt", err_cnt, 0);

    // early rlast on beat 2 of burst 0
    ar_delay = 0; rv_mode = 0;
    tick(2);
    rl_fault_en = 1; rl_fault_addr = 28'h020;
    ar_log.delete();
    pulse_start();
    wait_done(200, "t4");
    chk("t4_err_cnt",   err_cnt, 1);
    chk("t4_first_err", first_err_addr, 28'h020);
    if (ar_log.size() >= 2) chk("t4_ar1", ar_log[1], 28'h040);
    else chk("t4_ar_count", ar_log.size(), 2);
    rl_fault_en = 0;

    // start during a pass is ignored
    d0 = done_cnt;
    pulse_start();
    tick(4);
    pulse_start();
    wait_done(200, "t5");
    tick(3);
    chk("t5_done_cnt", done_cnt - d0, 1);
    chk("t5_busy",     busy, 0);

    // reset while reading burst 1
    flip_en = 1; flip_addr = 28'h010; flip_bit = 0;
    ar_log.delete();
    pulse_start();
    for (int k = 0; k < 100 && ar_log.size() < 2; k++) tick();
    chk("t6_pre_err", err_cnt, 1);
    rstn = 1'b0;
    tick();
    chk("t6_busy",    busy, 0);
    chk("t6_arvalid", bus.axi_arvalid, 0);
    chk("t6_rready",  bus.axi_rready, 0);
    chk("t6_err_cnt", err_cnt, 0);
    rstn = 1'b1;
    flip_en = 0;
    tick(2);

    // randomised passes
    for (int p = 0; p < 12; p++) begin
      ar_delay = $urandom_range(0, 3);
      rv_mode  = $urandom_range(0, 2);
      err_rate = $urandom_range(0, 2);
      spur_en  = ($urandom_range(0, 1) == 1);
      tick(2);
      pulse_start();
      wait_done(400, "rand");
    end

    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
